// File: rtl/drbg_word_serializer.sv
// DRBG word buffer and chunk serialiser feeding the scrambler key path.
// Words are split into OUT-bit chunks, popped per video line or by handshake.
module drbg_word_serializer #(
    parameter int DATA_WIDTH_IN  = 256,
    parameter int DATA_WIDTH_OUT = 8,
    parameter int DEPTH          = 2,
    parameter bit MSB_FIRST      = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         H,
    input  logic                         V,
    input  logic                         line_mode,
    input  logic [DATA_WIDTH_IN-1:0]     data_in,
    input  logic                         data_in_valid,
    input  logic                         generator_busy,
    output logic                         need_next,
    output logic [DATA_WIDTH_OUT-1:0]    data_out,
    output logic                         data_out_valid,
    input  logic                         data_out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int SLICES = DATA_WIDTH_IN / DATA_WIDTH_OUT;
    localparam int SW     = $clog2(SLICES);
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW     = $clog2(DEPTH + 1);

    localparam logic [SW-1:0] LAST_SLICE = SW'(SLICES - 1);
    localparam logic [LW-1:0] FULL       = LW'(DEPTH);

    logic [DATA_WIDTH_IN-1:0]  mem [DEPTH];
    logic [AW-1:0]             rd_ptr;
    logic [AW-1:0]             wr_ptr;
    logic [SW-1:0]             slice_ptr;
    logic                      prev_h;
    logic                      prev_v;
    logic                      outstanding;
    logic                      discard;

    logic                      v_rise;
    logic                      line_strobe;
    logic                      pop;
    logic                      last_pop;
    logic                      has_room;
    logic                      accept;
    logic                      push;
    logic                      drop;
    logic                      req;
    logic [LW:0]               pending;
    logic [DATA_WIDTH_IN-1:0]  head;
    logic [DATA_WIDTH_OUT-1:0] slices [SLICES];

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (DEPTH == 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        v_rise         = V & ~prev_v;
        line_strobe    = H & ~prev_h & ~V;
        data_out_valid = (level != '0);
        // A frame flush cancels any same-cycle pop and push.
        pop      = data_out_valid & ~v_rise
                 & (line_mode ? line_strobe : data_out_ready);
        last_pop = pop & (slice_ptr == LAST_SLICE);
        has_room = (level < FULL) | last_pop;
        accept   = data_in_valid & ~discard & ~v_rise;
        push     = accept & has_room;
        drop     = accept & ~has_room;
        pending  = {1'b0, level} + {{LW{1'b0}}, outstanding};
        req      = ~reset & ~outstanding & ~generator_busy & ~v_rise
                 & (pending < {1'b0, FULL});
        need_next = req;
    end

    always_comb begin
        head = mem[rd_ptr];
        for (int i = 0; i < SLICES; i++) begin
            if (MSB_FIRST)
                slices[i] = head[DATA_WIDTH_IN-1-i*DATA_WIDTH_OUT -: DATA_WIDTH_OUT];
            else
                slices[i] = head[i*DATA_WIDTH_OUT +: DATA_WIDTH_OUT];
        end
        data_out = data_out_valid ? slices[slice_ptr] : '0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            slice_ptr   <= '0;
            level       <= '0;
            prev_h      <= 1'b0;
            prev_v      <= 1'b0;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            prev_h <= H;
            prev_v <= V;
            if (v_rise) begin
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                slice_ptr <= '0;
                level     <= '0;
                // A request still in flight belongs to the old frame.
                discard     <= outstanding & ~data_in_valid;
                outstanding <= outstanding & ~data_in_valid;
            end else begin
                if (push) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (last_pop) begin
                    slice_ptr <= '0;
                    rd_ptr    <= ptr_inc(rd_ptr);
                end else if (pop) begin
                    slice_ptr <= slice_ptr + 1'b1;
                end
                unique case ({push, last_pop})
                    2'b10:   level <= level + 1'b1;
                    2'b01:   level <= level - 1'b1;
                    default: level <= level;
                endcase
                if (data_in_valid & discard) begin
                    discard <= 1'b0;
                end
                if (req) begin
                    outstanding <= 1'b1;
                end else if (data_in_valid) begin
                    outstanding <= 1'b0;
                end
                if (drop) begin
                    overflow <= 1'b1;
                end
                if (line_mode & line_strobe & ~data_out_valid) begin
                    underflow <= 1'b1;
                end
            end
        end
    end

endmodule
